// File: rtl/gate_pkg.sv
// Shared definitions for the gate result selector: op encodings and FIFO occupancy states.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PART,
    OCC_FULL
  } occ_e;

endpackage

// File: rtl/gate_popcount.sv
// Combinational population count of an N-bit vector.
module gate_popcount #(
  parameter int N = 4
) (
  input  logic [N-1:0]           data,
  output logic [$clog2(N+1)-1:0] ones
);

  localparam int OW = $clog2(N+1);

  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // update, so no path can leave it unassigned and infer a latch.
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + OW'(data[i]);
    end
  end

endmodule

// File: rtl/gate_result_sel.sv
// Selects one gate result by op and buffers {data, popcount, err} in a DEPTH-entry FIFO.
// Optional GATE_SEL_STATS_EN adds saturating acc_cnt/err_cnt statistics outputs.
module gate_result_sel
  import gate_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           y_and,
  input  logic [N-1:0]           y_or,
  input  logic [N-1:0]           y_nand,
  input  logic [N-1:0]           y_nor,
  input  logic [N-1:0]           y_xor,
  input  logic [N-1:0]           y_xnor,
  input  logic [2:0]             op,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(N+1)-1:0] out_ones,
  output logic                   out_err
`ifdef GATE_SEL_STATS_EN
  ,
  output logic [15:0]            acc_cnt,
  output logic [15:0]            err_cnt
`endif
);

  localparam int OW = $clog2(N+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]  sel_data;
  logic          sel_err;
  logic [OW-1:0] sel_ones;

  logic [N-1:0]  mem_data [DEPTH];
  logic [OW-1:0] mem_ones [DEPTH];
  logic          mem_err  [DEPTH];

  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  occ_e          occ, occ_nxt;
  logic          push, pop;

  // Illegal ops store an all-zero result flagged as an error.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b0;
    case (op)
      OP_AND:  sel_data = y_and;
      OP_OR:   sel_data = y_or;
      OP_NAND: sel_data = y_nand;
      OP_NOR:  sel_data = y_nor;
      OP_XOR:  sel_data = y_xor;
      OP_XNOR: sel_data = y_xnor;
      default: sel_err  = 1'b1;
    endcase
  end

  gate_popcount #(.N(N)) u_popcount (
    .data (sel_data),
    .ones (sel_ones)
  );

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (occ != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    if (count_nxt == '0)         occ_nxt = OCC_EMPTY;
    else if (count_nxt == DEPTH_C) occ_nxt = OCC_FULL;
    else                         occ_nxt = OCC_PART;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    if (rst) begin
      count <= '0;
      occ   <= OCC_EMPTY;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      count <= count_nxt;
      occ   <= occ_nxt;
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the outputs below are forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= sel_data;
      mem_ones[wptr] <= sel_ones;
      mem_err[wptr]  <= sel_err;
    end
  end

  assign out_data = out_valid ? mem_data[rptr] : '0;
  assign out_ones = out_valid ? mem_ones[rptr] : '0;
  assign out_err  = out_valid ? mem_err[rptr]  : 1'b0;

`ifdef GATE_SEL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
      err_cnt <= '0;
    end else if (push) begin
      if (acc_cnt != 16'hFFFF)            acc_cnt <= acc_cnt + 16'd1;
      if (sel_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_result_sel.sv
// Directed-vector bench for gate_result_sel (N=4, DEPTH=2).
module tb_gate_result_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] y_and = '0, y_or = '0, y_nand = '0, y_nor = '0, y_xor = '0, y_xnor = '0;
  logic [2:0] op = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [2:0] out_ones;
  logic       out_err;
`ifdef GATE_SEL_STATS_EN
  logic [15:0] acc_cnt, err_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gate_result_sel #(.N(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .y_and     (y_and),
    .y_or      (y_or),
    .y_nand    (y_nand),
    .y_nor     (y_nor),
    .y_xor     (y_xor),
    .y_xnor    (y_xnor),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ones  (out_ones),
    .out_err   (out_err)
`ifdef GATE_SEL_STATS_EN
    ,
    .acc_cnt   (acc_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_gates(input logic [3:0] a, input logic [3:0] b);
    y_and  = a & b;
    y_or   = a | b;
    y_nand = ~(a & b);
    y_nor  = ~(a | b);
    y_xor  = a ^ b;
    y_xnor = ~(a ^ b);
  endtask

  task automatic check_head(input string tag, input logic [3:0] d, input logic [2:0] n,
                            input logic e);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_ones"},  32'(out_ones),  32'(n));
    check({tag, "_err"},   32'(out_err),   32'(e));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_ones",  32'(out_ones),  32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    step();
    rst = 1'b0;
    step();

    // Basic xor select: a=1010 b=1100, no combinational forwarding when empty
    load_gates(4'b1010, 4'b1100);
    op = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("xor_nofwd", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check_head("xor", 4'b0110, 3'd2, 1'b0);
    step();
    check("xor_drained", 32'(out_valid), 32'd0);

    // Back-pressure: fill with and/or, third (xnor) waits for first pop
    out_ready = 1'b0;
    op = 3'd0; in_valid = 1'b1;
    step();
    check("bp_ready1", 32'(in_ready), 32'd1);
    op = 3'd1;
    step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    op = 3'd5;
    step();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check_head("bp_hold", 4'b1000, 3'd1, 1'b0);
    // Full with both sides active: one pop, no push
    out_ready = 1'b1;
    step();
    check("full_pp_ready", 32'(in_ready), 32'd1);
    check_head("bp_second", 4'b1110, 3'd3, 1'b0);
    step();
    in_valid = 1'b0;
    check_head("bp_third", 4'b1001, 3'd2, 1'b0);
    check("bp_third_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Illegal op
    op = 3'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_head("illegal", 4'b0000, 3'd0, 1'b1);
`ifdef GATE_SEL_STATS_EN
    check("stats_err1", 32'(err_cnt), 32'd1);
    check("stats_acc5", 32'(acc_cnt), 32'd5);
`endif
    step();
    check("illegal_drained", 32'(out_valid), 32'd0);

    // Streaming nor then nand with a=1111 b=0000
    load_gates(4'b1111, 4'b0000);
    op = 3'd3; in_valid = 1'b1;
    step();
    op = 3'd2;
    check_head("stream_nor", 4'b0000, 3'd0, 1'b0);
    step();
    in_valid = 1'b0;
    check_head("stream_nand", 4'b1111, 3'd4, 1'b0);
    step();
    check("stream_drained", 32'(out_valid), 32'd0);

    // Mid-operation reset with two entries buffered
    out_ready = 1'b0;
    op = 3'd0; in_valid = 1'b1;
    step();
    op = 3'd1;
    step();
    in_valid = 1'b0;
    check("prerst_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    check("midrst_data",  32'(out_data),  32'd0);
    step();
    check("midrst_hold_valid", 32'(out_valid), 32'd0);
    #2;
    rst = 1'b0;
    step();
    check("postrst_valid", 32'(out_valid), 32'd0);
    op = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_head("postrst_first", 4'b1111, 3'd4, 1'b0);
`ifdef GATE_SEL_STATS_EN
    check("stats_acc_after_rst", 32'(acc_cnt), 32'd1);
    check("stats_err_after_rst", 32'(err_cnt), 32'd0);
`endif
    step();
    check("postrst_drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
